// File: rtl/sal_multi_bank_sched_if.sv
// Bank request/grant bus and registered DFI command bus of the multi-bank scheduler.
// master = scheduler side, slave = bank controllers / DFI consumer side.
interface sal_multi_bank_sched_if #(
   parameter int BK_CNT = 4,
   parameter int BA_W   = 2,
   parameter int ADDR_W = 14
);
   logic [BK_CNT-1:0]        req_valid;
   logic [2*BK_CNT-1:0]      req_cmd;
   logic [ADDR_W*BK_CNT-1:0] req_addr;
   logic [BK_CNT-1:0]        gnt;
   logic                     dfi_cs_n;
   logic                     dfi_ras_n;
   logic                     dfi_cas_n;
   logic                     dfi_we_n;
   logic [BA_W-1:0]          dfi_bank;
   logic [ADDR_W-1:0]        dfi_address;

   modport master (
      input  req_valid, req_cmd, req_addr,
      output gnt, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address
   );

   modport slave (
      output req_valid, req_cmd, req_addr,
      input  gnt, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address
   );
endinterface

// File: rtl/sal_multi_bank_sched.sv
// Round-robin DDR2 command scheduler (optional CAS-first) with tWTR/tRTW/tRRD spacing.
// gnt is same-cycle combinational, DFI is registered (+1); a bank holds its request until granted.
module sal_multi_bank_sched #(
   parameter int BK_CNT = 4,
   parameter int BA_W   = 2,
   parameter int ADDR_W = 14,
   parameter int TMR_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sched_en,
   input  logic                  cas_first_en,
   input  logic [TMR_W-1:0]      twtr,
   input  logic [TMR_W-1:0]      trtw,
   input  logic [TMR_W-1:0]      trrd,
   sal_multi_bank_sched_if.master bus
);
   localparam int PTR_W = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;
   localparam logic [ADDR_W-1:0] A10_MASK = ADDR_W'(1) << 10;

   typedef enum logic [1:0] {CMD_ACT = 2'd0, CMD_RD = 2'd1, CMD_WR = 2'd2, CMD_PRE = 2'd3} cmd_e;

   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [TMR_W-1:0]  wr2rd_q, wr2rd_d, rd2wr_q, rd2wr_d, act2act_q, act2act_d;
   logic              cs_n_q, cs_n_d, ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
   logic [BA_W-1:0]   bank_q, bank_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic [BK_CNT-1:0] elig, cas_elig, cand, gnt;
   logic              gnt_vld;
   logic [PTR_W-1:0]  win, idx;
   cmd_e              win_cmd;
   logic [ADDR_W-1:0] win_addr;

   // Saturating decrement; also yields max(x,1)-1 when loading a timer from config.
   function automatic logic [TMR_W-1:0] dec_sat(input logic [TMR_W-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

   always_comb begin
      elig     = '0;
      cas_elig = '0;
      for (int b = 0; b < BK_CNT; b++) begin
         case (cmd_e'(bus.req_cmd[2*b +: 2]))
            CMD_RD:  elig[b] = bus.req_valid[b] && (wr2rd_q == '0);
            CMD_WR:  elig[b] = bus.req_valid[b] && (rd2wr_q == '0);
            CMD_ACT: elig[b] = bus.req_valid[b] && (act2act_q == '0);
            default: elig[b] = bus.req_valid[b];
         endcase
         cas_elig[b] = elig[b] && ((bus.req_cmd[2*b +: 2] == CMD_RD) ||
                                   (bus.req_cmd[2*b +: 2] == CMD_WR));
      end

      cand = (cas_first_en && (|cas_elig)) ? cas_elig : elig;
      if (!sched_en || !rst_n) begin
         cand = '0;
      end
      gnt_vld = |cand;

      // Scan from the far end back toward rr_ptr so the last hit is the first in rotation order.
      win = '0;
      idx = '0;
      for (int i = BK_CNT - 1; i >= 0; i--) begin
         idx = PTR_W'((int'(rr_ptr_q) + i) % BK_CNT);
         if (cand[idx]) begin
            win = idx;
         end
      end

      gnt      = gnt_vld ? (BK_CNT'(1) << win) : '0;
      win_cmd  = cmd_e'(bus.req_cmd[2*win +: 2]);
      win_addr = bus.req_addr[ADDR_W*win +: ADDR_W];

      rr_ptr_d  = rr_ptr_q;
      wr2rd_d   = dec_sat(wr2rd_q);
      rd2wr_d   = dec_sat(rd2wr_q);
      act2act_d = dec_sat(act2act_q);
      cs_n_d    = 1'b1;
      ras_n_d   = 1'b1;
      cas_n_d   = 1'b1;
      we_n_d    = 1'b1;
      bank_d    = bank_q;
      addr_d    = addr_q;

      if (gnt_vld) begin
         rr_ptr_d = (win == PTR_W'(BK_CNT - 1)) ? '0 : win + 1'b1;
         cs_n_d   = 1'b0;
         bank_d   = BA_W'(win);
         case (win_cmd)
            CMD_ACT: begin
               ras_n_d   = 1'b0;
               act2act_d = dec_sat(trrd);
               addr_d    = win_addr;
            end
            CMD_RD: begin
               cas_n_d = 1'b0;
               rd2wr_d = dec_sat(trtw);
               addr_d  = win_addr & ~A10_MASK;
            end
            CMD_WR: begin
               cas_n_d = 1'b0;
               we_n_d  = 1'b0;
               wr2rd_d = dec_sat(twtr);
               addr_d  = win_addr & ~A10_MASK;
            end
            default: begin
               ras_n_d = 1'b0;
               we_n_d  = 1'b0;
               addr_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q  <= '0;
         wr2rd_q   <= '0;
         rd2wr_q   <= '0;
         act2act_q <= '0;
         cs_n_q    <= 1'b1;
         ras_n_q   <= 1'b1;
         cas_n_q   <= 1'b1;
         we_n_q    <= 1'b1;
         bank_q    <= '0;
         addr_q    <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         wr2rd_q   <= wr2rd_d;
         rd2wr_q   <= rd2wr_d;
         act2act_q <= act2act_d;
         cs_n_q    <= cs_n_d;
         ras_n_q   <= ras_n_d;
         cas_n_q   <= cas_n_d;
         we_n_q    <= we_n_d;
         bank_q    <= bank_d;
         addr_q    <= addr_d;
      end
   end

   assign bus.gnt         = gnt;
   assign bus.dfi_cs_n    = cs_n_q;
   assign bus.dfi_ras_n   = ras_n_q;
   assign bus.dfi_cas_n   = cas_n_q;
   assign bus.dfi_we_n    = we_n_q;
   assign bus.dfi_bank    = bank_q;
   assign bus.dfi_address = addr_q;
endmodule

// File: tb/tb_sal_multi_bank_sched.sv
// Directed bench for sal_multi_bank_sched: inputs change at negedge, outputs sampled 1ns later.
module tb_sal_multi_bank_sched;
   localparam logic [1:0] C_ACT = 2'd0, C_RD = 2'd1, C_WR = 2'd2, C_PRE = 2'd3;
   localparam logic [3:0] NOP = 4'b1111, D_ACT = 4'b0011, D_RD = 4'b0101,
                          D_WR = 4'b0100, D_PRE = 4'b0010;

   logic       clk = 1'b0;
   logic       rst_n, sched_en, cas_first_en;
   logic [3:0] twtr, trtw, trrd;
   logic [3:0] dfi_c;
   int         n_tests = 0;
   int         n_fail  = 0;

   sal_multi_bank_sched_if #(.BK_CNT(4), .BA_W(2), .ADDR_W(14)) bus ();

   sal_multi_bank_sched #(.BK_CNT(4), .BA_W(2), .ADDR_W(14), .TMR_W(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sched_en     (sched_en),
      .cas_first_en (cas_first_en),
      .twtr         (twtr),
      .trtw         (trtw),
      .trrd         (trrd),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   assign dfi_c = {bus.dfi_cs_n, bus.dfi_ras_n, bus.dfi_cas_n, bus.dfi_we_n};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic set_req(input int b, input logic v, input logic [1:0] c, input logic [13:0] a);
      bus.req_valid[b]        = v;
      bus.req_cmd[2*b +: 2]   = c;
      bus.req_addr[14*b +: 14] = a;
   endtask

   task automatic do_reset();
      bus.req_valid = '0;
      rst_n = 1'b0;
      nxt();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      rst_n = 1'b0; sched_en = 1'b1; cas_first_en = 1'b0;
      twtr = 4'd0; trtw = 4'd0; trrd = 4'd0;
      bus.req_cmd = '0; bus.req_addr = '0; bus.req_valid = '0;
      for (int b = 0; b < 4; b++) set_req(b, 1'b1, C_PRE, 14'h1234);

      // reset state: gnt gated even with requests pending
      nxt(); nxt(); #1;
      chk("rst_gnt", bus.gnt, 4'b0000);
      chk("rst_dfi_cmd", dfi_c, NOP);
      chk("rst_dfi_bank", bus.dfi_bank, 2'd0);
      chk("rst_dfi_addr", bus.dfi_address, 14'h0);

      // continuous PRE from all banks: pure rotation
      rst_n = 1'b1; #1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin nxt(); #1; end
         e = 1 << (k % 4);
         chk("rr_gnt", bus.gnt, e);
         if (k > 0) begin
            chk("rr_dfi_cmd", dfi_c, D_PRE);
            chk("rr_dfi_bank", bus.dfi_bank, (k - 1) % 4);
            chk("rr_dfi_addr", bus.dfi_address, 14'h0);
         end
      end

      // twtr = 4: WR at t, pending RD granted at t+4
      nxt(); do_reset(); twtr = 4'd4;
      set_req(0, 1'b1, C_WR, 14'h3FFF); set_req(1, 1'b1, C_RD, 14'h0455); #1;
      chk("twtr_t0_gnt", bus.gnt, 4'b0001);
      nxt(); bus.req_valid[0] = 1'b0; #1;
      chk("twtr_t1_gnt", bus.gnt, 4'b0000);
      chk("twtr_t1_cmd", dfi_c, D_WR);
      chk("twtr_t1_bank", bus.dfi_bank, 2'd0);
      chk("twtr_t1_addr", bus.dfi_address, 14'h3BFF);
      nxt(); #1;
      chk("twtr_t2_gnt", bus.gnt, 4'b0000);
      chk("twtr_t2_cmd", dfi_c, NOP);
      chk("twtr_t2_addr_hold", bus.dfi_address, 14'h3BFF);
      nxt(); #1;
      chk("twtr_t3_gnt", bus.gnt, 4'b0000);
      nxt(); #1;
      chk("twtr_t4_gnt", bus.gnt, 4'b0010);
      nxt(); bus.req_valid[1] = 1'b0; #1;
      chk("twtr_t5_gnt", bus.gnt, 4'b0000);
      chk("twtr_t5_cmd", dfi_c, D_RD);
      chk("twtr_t5_bank", bus.dfi_bank, 2'd1);
      chk("twtr_t5_addr", bus.dfi_address, 14'h0055);

      // trtw = 3, trrd = 2, mixed traffic with PRE filling the gap
      nxt(); do_reset(); twtr = 4'd1; trtw = 4'd3; trrd = 4'd2;
      set_req(0, 1'b1, C_RD, 14'h0011); set_req(1, 1'b1, C_WR, 14'h0022);
      set_req(2, 1'b1, C_ACT, 14'h0400); set_req(3, 1'b1, C_ACT, 14'h1ABC); #1;
      chk("mix_t0_gnt", bus.gnt, 4'b0001);
      nxt(); set_req(0, 1'b1, C_PRE, 14'h0777); #1;
      chk("mix_t1_gnt", bus.gnt, 4'b0100);
      chk("mix_t1_cmd", dfi_c, D_RD);
      chk("mix_t1_addr", bus.dfi_address, 14'h0011);
      nxt(); bus.req_valid[2] = 1'b0; #1;
      chk("mix_t2_gnt", bus.gnt, 4'b0001);
      chk("mix_t2_cmd", dfi_c, D_ACT);
      chk("mix_t2_bank", bus.dfi_bank, 2'd2);
      chk("mix_t2_addr", bus.dfi_address, 14'h0400);
      nxt(); bus.req_valid[0] = 1'b0; #1;
      chk("mix_t3_gnt", bus.gnt, 4'b0010);
      chk("mix_t3_cmd", dfi_c, D_PRE);
      chk("mix_t3_addr", bus.dfi_address, 14'h0);
      nxt(); bus.req_valid[1] = 1'b0; #1;
      chk("mix_t4_gnt", bus.gnt, 4'b1000);
      chk("mix_t4_cmd", dfi_c, D_WR);
      chk("mix_t4_bank", bus.dfi_bank, 2'd1);
      nxt(); bus.req_valid[3] = 1'b0; #1;
      chk("mix_t5_gnt", bus.gnt, 4'b0000);
      chk("mix_t5_cmd", dfi_c, D_ACT);
      chk("mix_t5_addr", bus.dfi_address, 14'h1ABC);

      // CAS-first on and off
      nxt(); do_reset(); twtr = 4'd0; trtw = 4'd0; trrd = 4'd0; cas_first_en = 1'b1;
      set_req(0, 1'b1, C_ACT, 14'h0100); set_req(2, 1'b1, C_RD, 14'h0200); #1;
      chk("casf_on_first", bus.gnt, 4'b0100);
      nxt(); bus.req_valid[2] = 1'b0; #1;
      chk("casf_on_second", bus.gnt, 4'b0001);
      nxt(); do_reset(); cas_first_en = 1'b0;
      set_req(0, 1'b1, C_ACT, 14'h0100); set_req(2, 1'b1, C_RD, 14'h0200); #1;
      chk("casf_off_first", bus.gnt, 4'b0001);

      // sched_en low for 5 cycles: no grants, timers still run, rr_ptr held
      nxt(); do_reset(); twtr = 4'd6;
      set_req(1, 1'b1, C_WR, 14'h0033); #1;
      chk("hold_pre_gnt", bus.gnt, 4'b0010);
      nxt(); sched_en = 1'b0;
      set_req(0, 1'b1, C_PRE, 14'h0); set_req(1, 1'b1, C_PRE, 14'h0);
      set_req(2, 1'b1, C_RD, 14'h0044); set_req(3, 1'b1, C_PRE, 14'h0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold_gnt", bus.gnt, 4'b0000);
         if (i > 0) chk("hold_cs_n", bus.dfi_cs_n, 1'b1);
         nxt();
      end
      sched_en = 1'b1; #1;
      chk("hold_last_cs_n", bus.dfi_cs_n, 1'b1);
      chk("hold_reen_gnt", bus.gnt, 4'b0100);

      // reset pulse during traffic with a loaded timer
      nxt(); do_reset(); twtr = 4'd8;
      set_req(1, 1'b1, C_WR, 14'h0066); #1;
      chk("rstmid_t0_gnt", bus.gnt, 4'b0010);
      nxt(); bus.req_valid[1] = 1'b0;
      set_req(2, 1'b1, C_RD, 14'h0077); set_req(3, 1'b1, C_PRE, 14'h0);
      rst_n = 1'b0; #1;
      chk("rstmid_low_gnt", bus.gnt, 4'b0000);
      nxt(); rst_n = 1'b1; #1;
      chk("rstmid_dfi_cmd", dfi_c, NOP);
      chk("rstmid_dfi_bank", bus.dfi_bank, 2'd0);
      chk("rstmid_dfi_addr", bus.dfi_address, 14'h0);
      chk("rstmid_first_gnt", bus.gnt, 4'b0100);
      nxt(); bus.req_valid[2] = 1'b0; #1;
      chk("rstmid_rd_cmd", dfi_c, D_RD);
      chk("rstmid_rd_bank", bus.dfi_bank, 2'd2);
      chk("rstmid_rd_addr", bus.dfi_address, 14'h0077);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
